// File: rtl/fp_vector_checker.sv
// fp_vector_checker: streams test vectors from a synchronous ROM into an FP unit,
// delays each expected result and flag set by the unit's latency, and keeps
// pass/fail statistics for the run.
module fp_vector_checker #(
  parameter int FLEN      = 32,
  parameter int FLAGW     = 5,
  parameter int DEPTH     = 1024,
  parameter int LAT       = 2,
  parameter int NAN_CANON = 1,
  localparam int ADDRW    = $clog2(DEPTH),
  localparam int VW       = 3*FLEN+8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [2:0]       rm_in_i,
  input  logic [ADDRW:0]   num_vec_i,
  input  logic             cmp_flags_i,
  output logic [ADDRW-1:0] vec_addr_o,
  input  logic [VW-1:0]    vec_data_i,
  output logic [FLEN-1:0]  dut_op1_o,
  output logic [FLEN-1:0]  dut_op2_o,
  output logic [2:0]       dut_rm_o,
  output logic             dut_valid_o,
  input  logic [FLEN-1:0]  dut_result_i,
  input  logic [FLAGW-1:0] dut_flags_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             mismatch_o,
  output logic [31:0]      err_count_o,
  output logic [ADDRW:0]   vec_count_o,
  output logic [ADDRW-1:0] first_err_idx_o,
  output logic             first_err_valid_o
);

  localparam int EXPW  = (FLEN == 64) ? 11 : 8;
  localparam int FRACW = FLEN - 1 - EXPW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  logic             startAccept;
  logic             issueEn;
  logic [2:0]       rm_q;
  logic [ADDRW:0]   numVec_q;
  logic             cmpFlags_q;
  logic [ADDRW-1:0] lastIdx;
  logic [ADDRW-1:0] issueIdx_q;
  logic             romValid_q;
  logic [ADDRW-1:0] romIdx_q;
  logic [FLEN-1:0]  op1_q, op2_q;

  // Expected data pipeline; stage 0 lines up with the operands, stage LAT with the result.
  logic             pipeValid_q [0:LAT];
  logic [ADDRW-1:0] pipeIdx_q   [0:LAT];
  logic [FLEN-1:0]  pipeExp_q   [0:LAT];
  logic [FLAGW-1:0] pipeFlags_q [0:LAT];

  logic             alignedValid;
  logic [ADDRW-1:0] alignedIdx;
  logic [FLEN-1:0]  alignedExp;
  logic [FLAGW-1:0] alignedFlags;
  logic             expIsNan, resIsNan, resultOk, flagsOk, vecFail, lastCompare;
  logic             unusedVecBits;

  logic             mismatch_q;
  logic [31:0]      errCount_q;
  logic [ADDRW:0]   vecCount_q;
  logic [ADDRW-1:0] firstErrIdx_q;
  logic             firstErrValid_q;

  // The upper flag-byte bits are carried in the vector format but never compared.
  assign unusedVecBits = ^vec_data_i[7:0];

  assign lastIdx      = ADDRW'(numVec_q - (ADDRW+1)'(1));
  assign alignedValid = pipeValid_q[LAT];
  assign alignedIdx   = pipeIdx_q[LAT];
  assign alignedExp   = pipeExp_q[LAT];
  assign alignedFlags = pipeFlags_q[LAT];
  assign lastCompare  = alignedValid && (alignedIdx == lastIdx);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: issue num_vec addresses, then wait for the last compare to land.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_i) state_d = (num_vec_i == '0) ? DONE : RUN;
      RUN:        if (issueIdx_q == lastIdx) state_d = DRAIN;
      DRAIN:      if (lastCompare) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // FSM outputs; start is only honoured while not running.
  always_comb begin
    busy_o      = 1'b0;
    done_o      = 1'b0;
    issueEn     = 1'b0;
    startAccept = 1'b0;
    case (state_q)
      IDLE:    startAccept = start_i;
      RUN:     begin busy_o = 1'b1; issueEn = 1'b1; end
      DRAIN:   busy_o = 1'b1;
      DONE:    begin done_o = 1'b1; startAccept = start_i; end
      default: ;
    endcase
  end

  // Run configuration is captured once per start so it stays stable for the whole run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rm_q       <= '0;
      numVec_q   <= '0;
      cmpFlags_q <= 1'b0;
    end else if (startAccept) begin
      rm_q       <= rm_in_i;
      numVec_q   <= num_vec_i;
      cmpFlags_q <= cmp_flags_i;
    end
  end

  // Address issue; the valid/index pair marks which cycle's ROM data is a real vector.
  always_ff @(posedge clk) begin
    if (!reset) begin
      issueIdx_q <= '0;
      romValid_q <= 1'b0;
      romIdx_q   <= '0;
    end else begin
      romValid_q <= issueEn;
      romIdx_q   <= issueIdx_q;
      if (startAccept)  issueIdx_q <= '0;
      else if (issueEn) issueIdx_q <= issueIdx_q + ADDRW'(1);
    end
  end

  // Operand registers feeding the FP unit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op1_q <= '0;
      op2_q <= '0;
    end else if (romValid_q) begin
      op1_q <= vec_data_i[VW-1 -: FLEN];
      op2_q <= vec_data_i[VW-1-FLEN -: FLEN];
    end
  end

  // Expected/flags/index shift register matching the unit's latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j <= LAT; j++) begin
        pipeValid_q[j] <= 1'b0;
        pipeIdx_q[j]   <= '0;
        pipeExp_q[j]   <= '0;
        pipeFlags_q[j] <= '0;
      end
    end else begin
      pipeValid_q[0] <= romValid_q;
      pipeIdx_q[0]   <= romIdx_q;
      pipeExp_q[0]   <= vec_data_i[FLEN+7 -: FLEN];
      pipeFlags_q[0] <= vec_data_i[FLAGW-1:0];
      for (int j = 1; j <= LAT; j++) begin
        pipeValid_q[j] <= pipeValid_q[j-1];
        pipeIdx_q[j]   <= pipeIdx_q[j-1];
        pipeExp_q[j]   <= pipeExp_q[j-1];
        pipeFlags_q[j] <= pipeFlags_q[j-1];
      end
    end
  end

  // Pass/fail decision; any NaN result satisfies an expected NaN when canonicalisation is on.
  always_comb begin
    expIsNan = (&alignedExp[FLEN-2 -: EXPW]) && (|alignedExp[FRACW-1:0]);
    resIsNan = (&dut_result_i[FLEN-2 -: EXPW]) && (|dut_result_i[FRACW-1:0]);
    resultOk = (dut_result_i == alignedExp) || ((NAN_CANON != 0) && expIsNan && resIsNan);
    flagsOk  = !cmpFlags_q || (dut_flags_i == alignedFlags);
    vecFail  = !(resultOk && flagsOk);
  end

  // Registered statistics; a start clears them, each aligned compare updates them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mismatch_q      <= 1'b0;
      errCount_q      <= '0;
      vecCount_q      <= '0;
      firstErrIdx_q   <= '0;
      firstErrValid_q <= 1'b0;
    end else if (startAccept) begin
      mismatch_q      <= 1'b0;
      errCount_q      <= '0;
      vecCount_q      <= '0;
      firstErrValid_q <= 1'b0;
    end else begin
      mismatch_q <= 1'b0;
      if (alignedValid) begin
        vecCount_q <= vecCount_q + (ADDRW+1)'(1);
        if (vecFail) begin
          mismatch_q <= 1'b1;
          if (errCount_q != 32'hFFFF_FFFF) errCount_q <= errCount_q + 32'd1;
          if (!firstErrValid_q) begin
            firstErrIdx_q   <= alignedIdx;
            firstErrValid_q <= 1'b1;
          end
        end
      end
    end
  end

  assign vec_addr_o        = issueIdx_q;
  assign dut_op1_o         = op1_q;
  assign dut_op2_o         = op2_q;
  assign dut_rm_o          = rm_q;
  assign dut_valid_o       = pipeValid_q[0];
  assign mismatch_o        = mismatch_q;
  assign err_count_o       = errCount_q;
  assign vec_count_o       = vecCount_q;
  assign first_err_idx_o   = firstErrIdx_q;
  assign first_err_valid_o = firstErrValid_q;

endmodule

// File: doc/fp_vector_checker.md
# fp_vector_checker

Synthesizable, parametrised self-checking harness for floating-point datapath units such as `fpadd`. It streams test vectors `{op1, op2, expected, flags_expected}` from a synchronous vector ROM and drives them into a DUT of configurable precision, latency and rounding mode. It aligns the expected values with the DUT's pipeline latency, compares result and flags, and reports error counts and the first failing index. It sits beside the FP unit in on-chip regression and FPGA bring-up builds.

## Interface
- FLEN, 32: operand/result width (32 or 64).
- FLAGW, 5: DUT flag width; vector flag byte bits [FLAGW-1:0] used.
- DEPTH, 1024: vector ROM entries; ADDRW = $clog2(DEPTH).
- LAT, 2: DUT latency in cycles from operands valid to result valid (0 = combinational).
- NAN_CANON, 1: 1 = any NaN result matches an expected NaN.
- VW = 3*FLEN+8: vector width, layout {op1, op2, expected, flags[7:0]}, MSB first.

- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- start  in  1  begin run; sampled in IDLE or DONE only.
- rm_in  in  3  rounding mode, latched at start.
- num_vec  in  ADDRW+1  vectors to run, latched at start.
- cmp_flags  in  1  include flags in compare, latched at start.
- vec_addr  out  ADDRW  ROM address; data returns 1 cycle later.
- vec_data  in  VW  ROM read data.
- dut_op1, dut_op2  out  FLEN  registered operands.
- dut_rm  out  3  latched rounding mode.
- dut_valid  out  1  operands valid this cycle.
- dut_result  in  FLEN  DUT result.
- dut_flags  in  FLAGW  DUT flags.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  high in DONE.
- mismatch  out  1  one-cycle pulse per failing vector.
- err_count  out  32  failing vectors; saturates at 32'hFFFF_FFFF.
- vec_count  out  ADDRW+1  vectors compared.
- first_err_idx  out  ADDRW  index of first failure.
- first_err_valid  out  1  first_err_idx is meaningful.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: latch rm_in/num_vec/cmp_flags; clear err_count, vec_count, first_err_valid. num_vec=0 goes directly to DONE. Otherwise go to RUN with issue index i=0.
- RUN: vec_addr=i each cycle, i++. After issuing address num_vec-1, go to DRAIN.
- Pipeline: ROM data is registered into dut_op1/op2 with dut_valid=1. Expected and flags travel through a LAT-stage shift register with a valid bit and the vector index.
- Compare in the cycle the aligned valid is high. Fail if result≠expected, or if cmp_flags and dut_flags≠flags[FLAGW-1:0]. With NAN_CANON, an expected NaN (exp all ones, fraction≠0) matches any NaN result.
- Compare outcome is registered: vec_count++, plus on fail: mismatch pulse, err_count++ (saturating), and first_err_idx/first_err_valid set if not already valid.
- DRAIN: on the last compare's registered update, go to DONE.
- DONE: holds counters and done=1 until the next start.
- start in RUN/DRAIN is ignored.

## Timing
- Reset values: state IDLE, all outputs 0 (vec_addr 0, dut_rm 0, counters 0, flags low).
- Reset asserted mid-run aborts immediately to reset values; in-flight pipeline valids are cleared.
- Cycle 0 = start sampled. Vector k: vec_addr in cycle k+1, vec_data in k+2, dut_valid in k+3, compare in k+3+LAT, counters visible in k+4+LAT.
- done first high in cycle num_vec+3+LAT, the same cycle the final counters are visible.
- Throughput: one vector per cycle, no bubbles.
- vec_count wraps never; max num_vec = DEPTH.

## Test plan
- Four passing f32 vectors (e.g. 3F800000+40000000→40400000, flags 00), LAT=2 → err_count 0, vec_count 4, done at cycle 9, mismatch never pulses.
- Eight vectors with a corrupted expected at index 2 and index 5 → err_count 2, first_err_idx 2, mismatch pulses in cycles 8 and 11.
- Expected 7FC00000, DUT returns 7FA00001: NAN_CANON=1 → pass; NAN_CANON=0 → err_count 1.
- Flags differ (expected 00, DUT 01): cmp_flags=0 → pass; cmp_flags=1 → err_count 1.
- num_vec=0 → done in cycle 1, counts 0, dut_valid never high. Start during RUN is ignored and the run completes normally.
- reset low in cycle 5 of a 10-vector run → next cycle all outputs are 0 and state is IDLE. A fresh start then runs 10 vectors with correct counts and no stale compares.
